// File: rtl/ccm_pkg.sv
// Shared CCM definitions: default field widths and counter-block assembly.
// Used by the CTR keystream pipeline and the CCM-MAC block.
package ccm_pkg;

    localparam int CCM_WIDTH_NONCE = 100;
    localparam int CCM_WIDTH_FLAG  = 8;
    localparam int CCM_WIDTH_COUNT = 20;
    localparam int CCM_WIDTH_KEY   = CCM_WIDTH_FLAG + CCM_WIDTH_NONCE + CCM_WIDTH_COUNT;

    function automatic logic [CCM_WIDTH_KEY-1:0] ccm_block(
        input logic [CCM_WIDTH_FLAG-1:0]  flag,
        input logic [CCM_WIDTH_NONCE-1:0] nonce,
        input logic [CCM_WIDTH_COUNT-1:0] ctr
    );
        return {flag, nonce, ctr};
    endfunction

endpackage

// File: rtl/ccm_sync_fifo.sv
// Fall-through synchronous FIFO: rd_data shows the head entry whenever empty=0.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module ccm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ccm_ctr_pipe_fake_aes.sv
// CTR-mode keystream generator: {flag, nonce, ctr} ^ key behind a fixed-latency
// stand-in for the AES core, with credit-based backpressure into an output FIFO.
module ccm_ctr_pipe_fake_aes
    import ccm_pkg::*;
#(
    parameter int T_DLY       = 3,
    parameter int WIDTH_NONCE = CCM_WIDTH_NONCE,
    parameter int WIDTH_FLAG  = CCM_WIDTH_FLAG,
    parameter int WIDTH_COUNT = CCM_WIDTH_COUNT,
    parameter int FIFO_DEPTH  = 4,
    localparam int WIDTH_KEY  = WIDTH_FLAG + WIDTH_NONCE + WIDTH_COUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH_KEY-1:0]   key_aes,
    input  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce,
    input  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag,
    input  logic [WIDTH_COUNT-1:0] ctr_init,
    input  logic                   load,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [WIDTH_KEY-1:0]   ks_data,
    output logic [WIDTH_COUNT-1:0] ks_ctr,
    output logic                   ks_valid,
    input  logic                   ks_ready,
    output logic                   busy,
    output logic                   ctr_wrap
);

    localparam int STAGES = T_DLY - 1;
    localparam int EW     = WIDTH_KEY + WIDTH_COUNT;
    localparam int OC_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [OC_W-1:0] OC_MAX = OC_W'(FIFO_DEPTH);

    logic [WIDTH_NONCE-1:0] nonce_r;
    logic [WIDTH_FLAG-1:0]  flag_r;
    logic [WIDTH_COUNT-1:0] ctr;
    logic [OC_W-1:0]        oc;

    logic [WIDTH_NONCE-1:0] cur_nonce;
    logic [WIDTH_FLAG-1:0]  cur_flag;
    logic [WIDTH_COUNT-1:0] cur_ctr;
    logic [WIDTH_KEY-1:0]   blk;
    logic                   accept;
    logic                   pop;

    logic          fifo_wr_en;
    logic [EW-1:0] fifo_wr_data;
    logic [EW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_full;

    // A load coinciding with an accept feeds the new fields straight into that block.
    assign cur_nonce = load ? ccm_ctr_nonce : nonce_r;
    assign cur_flag  = load ? ccm_ctr_flag  : flag_r;
    assign cur_ctr   = load ? ctr_init      : ctr;
    assign blk       = {cur_flag, cur_nonce, cur_ctr} ^ key_aes;

    assign req_ready = reset && (oc < OC_MAX);
    assign accept    = req_valid && req_ready;
    assign ks_valid  = !fifo_empty;
    assign pop       = ks_valid && ks_ready;
    assign busy      = (oc != '0);
    assign ks_data   = ks_valid ? fifo_rd_data[EW-1:WIDTH_COUNT] : '0;
    assign ks_ctr    = ks_valid ? fifo_rd_data[WIDTH_COUNT-1:0]  : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nonce_r  <= '0;
            flag_r   <= '0;
            ctr      <= '0;
            ctr_wrap <= 1'b0;
            oc       <= '0;
        end else begin
            if (load) begin
                nonce_r <= ccm_ctr_nonce;
                flag_r  <= ccm_ctr_flag;
            end
            if (accept)
                ctr <= cur_ctr + WIDTH_COUNT'(1);
            else if (load)
                ctr <= ctr_init;
            if (load)
                ctr_wrap <= 1'b0;
            else if (accept && (&ctr))
                ctr_wrap <= 1'b1;
            if (accept && !pop)
                oc <= oc + OC_W'(1);
            else if (pop && !accept)
                oc <= oc - OC_W'(1);
        end
    end

    generate
        if (STAGES == 0) begin : g_direct
            assign fifo_wr_en   = accept;
            assign fifo_wr_data = {blk, cur_ctr};
        end else begin : g_pipe
            logic [STAGES-1:0] pipe_valid;
            logic [EW-1:0]     pipe_entry [STAGES];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= accept;
                    for (int i = 1; i < STAGES; i++)
                        pipe_valid[i] <= pipe_valid[i-1];
                end
            end

            always_ff @(posedge clk) begin
                pipe_entry[0] <= {blk, cur_ctr};
                for (int i = 1; i < STAGES; i++)
                    pipe_entry[i] <= pipe_entry[i-1];
            end

            assign fifo_wr_en   = pipe_valid[STAGES-1];
            assign fifo_wr_data = pipe_entry[STAGES-1];
        end
    endgenerate

    ccm_sync_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (fifo_wr_en),
        .wr_data(fifo_wr_data),
        .rd_en  (pop),
        .rd_data(fifo_rd_data),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    // Credits bound pipeline plus FIFO occupancy, so a write never meets a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) fifo_wr_en |-> !fifo_full);

endmodule

// File: tb/tb_ccm_ctr_pipe_fake_aes.sv
// Self-checking bench for ccm_ctr_pipe_fake_aes: a reference model pushes expected
// blocks on every accept and compares them in order as the DUT pops them.
module tb_ccm_ctr_pipe_fake_aes;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] key_aes = '0;
    logic [99:0]  ccm_ctr_nonce = '0;
    logic [7:0]   ccm_ctr_flag = '0;
    logic [19:0]  ctr_init = '0;
    logic         load = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [127:0] ks_data;
    logic [19:0]  ks_ctr;
    logic         ks_valid;
    logic         ks_ready = 1'b0;
    logic         busy;
    logic         ctr_wrap;

    logic         load1 = 1'b0;
    logic         req_valid1 = 1'b0;
    logic         req_ready1;
    logic [127:0] ks_data1;
    logic [19:0]  ks_ctr1;
    logic         ks_valid1;
    logic         ks_ready1 = 1'b1;
    logic         busy1;
    logic         ctr_wrap1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] data;
        logic [19:0]  ctr;
    } exp_t;

    exp_t         sb[$];
    logic [19:0]  popped_ctr[$];
    logic [127:0] popped_data[$];

    logic [99:0]  m_nonce = '0;
    logic [7:0]   m_flag = '0;
    logic [19:0]  m_ctr = '0;
    logic         m_wrap = 1'b0;

    always #5 clk = ~clk;

    ccm_ctr_pipe_fake_aes #(.T_DLY(3)) dut (
        .clk(clk), .reset(reset), .key_aes(key_aes), .ccm_ctr_nonce(ccm_ctr_nonce),
        .ccm_ctr_flag(ccm_ctr_flag), .ctr_init(ctr_init), .load(load),
        .req_valid(req_valid), .req_ready(req_ready), .ks_data(ks_data), .ks_ctr(ks_ctr),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy), .ctr_wrap(ctr_wrap)
    );

    ccm_ctr_pipe_fake_aes #(.T_DLY(1)) dut1 (
        .clk(clk), .reset(reset), .key_aes(key_aes), .ccm_ctr_nonce(ccm_ctr_nonce),
        .ccm_ctr_flag(ccm_ctr_flag), .ctr_init(ctr_init), .load(load1),
        .req_valid(req_valid1), .req_ready(req_ready1), .ks_data(ks_data1), .ks_ctr(ks_ctr1),
        .ks_valid(ks_valid1), .ks_ready(ks_ready1), .busy(busy1), .ctr_wrap(ctr_wrap1)
    );

    // Reference model and scoreboard, evaluated on the falling edge where inputs are stable.
    always @(negedge clk) begin
        logic [99:0] cn;
        logic [7:0]  cf;
        logic [19:0] cc;
        logic        acc;
        exp_t        e;
        if (!reset) begin
            sb.delete();
            m_nonce = '0;
            m_flag  = '0;
            m_ctr   = '0;
            m_wrap  = 1'b0;
        end else begin
            n_checks++;
            if (ctr_wrap !== m_wrap) begin
                n_fail++;
                $display("[TB] FAIL model_ctr_wrap: got %b expected %b", ctr_wrap, m_wrap);
            end
            if (ks_valid && ks_ready) begin
                popped_ctr.push_back(ks_ctr);
                popped_data.push_back(ks_data);
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected: got ks_ctr=%h with nothing expected", ks_ctr);
                end else begin
                    e = sb.pop_front();
                    if (ks_data !== e.data || ks_ctr !== e.ctr) begin
                        n_fail++;
                        $display("[TB] FAIL sb_block: got data=%h ctr=%h expected data=%h ctr=%h",
                                 ks_data, ks_ctr, e.data, e.ctr);
                    end
                end
            end
            cn  = load ? ccm_ctr_nonce : m_nonce;
            cf  = load ? ccm_ctr_flag  : m_flag;
            cc  = load ? ctr_init      : m_ctr;
            acc = req_valid && req_ready;
            if (acc) begin
                e.data = {cf, cn, cc} ^ key_aes;
                e.ctr  = cc;
                sb.push_back(e);
            end
            if (load)
                m_wrap = 1'b0;
            else if (acc && m_ctr == 20'hFFFFF)
                m_wrap = 1'b1;
            if (acc)
                m_ctr = cc + 20'd1;
            else if (load)
                m_ctr = ctr_init;
            if (load) begin
                m_nonce = ccm_ctr_nonce;
                m_flag  = ccm_ctr_flag;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks += 6;
        if (ks_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ks_valid: got %b expected 0", ks_valid); end
        if (ks_data !== '0) begin n_fail++; $display("[TB] FAIL reset_ks_data: got %h expected 0", ks_data); end
        if (ks_ctr !== '0) begin n_fail++; $display("[TB] FAIL reset_ks_ctr: got %h expected 0", ks_ctr); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
        if (ctr_wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ctr_wrap: got %b expected 0", ctr_wrap); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_req_ready: got %b expected 1", req_ready); end
        tick();
    endtask

    task automatic test_single();
        logic [127:0] exp1 = {8'h59, 100'h1, 20'h0};
        key_aes = '0; ccm_ctr_nonce = 100'h1; ccm_ctr_flag = 8'h59; ctr_init = 20'h0;
        load = 1'b1; tick(); load = 1'b0;
        ks_ready = 1'b1; req_valid = 1'b1; tick(); req_valid = 1'b0;
        n_checks += 2;
        if (ks_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_e0: got ks_valid=%b expected 0", ks_valid); end
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        tick();
        n_checks++;
        if (ks_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_e1: got ks_valid=%b expected 0", ks_valid); end
        tick();
        n_checks += 3;
        if (ks_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_latency: got ks_valid=%b expected 1", ks_valid); end
        if (ks_data !== exp1) begin n_fail++; $display("[TB] FAIL single_data: got %h expected %h", ks_data, exp1); end
        if (ks_ctr !== 20'h0) begin n_fail++; $display("[TB] FAIL single_ctr: got %h expected 0", ks_ctr); end
        tick();
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_after_pop: got %b expected 0", busy); end
        if (ks_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_valid_after_pop: got %b expected 0", ks_valid); end
        if (ks_data !== '0) begin n_fail++; $display("[TB] FAIL single_data_idle: got %h expected 0", ks_data); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        ctr_init = 20'h0; load = 1'b1; tick(); load = 1'b0;
        ks_ready = 1'b0; req_valid = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        n_checks += 2;
        if (acc != 4) begin n_fail++; $display("[TB] FAIL bp_accepts: got %0d expected 4", acc); end
        if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_req_ready_full: got %b expected 0", req_ready); end
        popped_ctr.delete();
        ks_ready = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (ks_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid: got %b expected 1", ks_valid); end
        if (ks_ctr !== 20'h0) begin n_fail++; $display("[TB] FAIL bp_first_ctr: got %h expected 0", ks_ctr); end
        if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_before_pop: got %b expected 0", req_ready); end
        tick();
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_after_pop: got %b expected 1", req_ready); end
        wait_idle();
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drain_timeout: got busy=%b expected 0", busy); end
        if (popped_ctr.size() != 4) begin n_fail++; $display("[TB] FAIL bp_count: got %0d expected 4", popped_ctr.size()); end
        for (int i = 0; i < popped_ctr.size() && i < 4; i++) begin
            n_checks++;
            if (popped_ctr[i] !== 20'(i)) begin n_fail++; $display("[TB] FAIL bp_order[%0d]: got %h expected %h", i, popped_ctr[i], i); end
        end
    endtask

    task automatic test_wrap();
        logic [19:0] exp_ctr[3] = '{20'hFFFFE, 20'hFFFFF, 20'h0};
        ctr_init = 20'hFFFFE; load = 1'b1; tick(); load = 1'b0;
        popped_ctr.delete();
        ks_ready = 1'b1; req_valid = 1'b1;
        tick();
        n_checks++;
        if (ctr_wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_first: got %b expected 0", ctr_wrap); end
        tick();
        n_checks++;
        if (ctr_wrap !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_second: got %b expected 1", ctr_wrap); end
        tick();
        req_valid = 1'b0;
        wait_idle();
        n_checks += 2;
        if (ctr_wrap !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_sticky: got %b expected 1", ctr_wrap); end
        if (popped_ctr.size() != 3) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 3", popped_ctr.size()); end
        for (int i = 0; i < popped_ctr.size() && i < 3; i++) begin
            n_checks++;
            if (popped_ctr[i] !== exp_ctr[i]) begin n_fail++; $display("[TB] FAIL wrap_ctr[%0d]: got %h expected %h", i, popped_ctr[i], exp_ctr[i]); end
        end
        ctr_init = 20'h0; load = 1'b1; tick(); load = 1'b0;
        n_checks++;
        if (ctr_wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_clear: got %b expected 0", ctr_wrap); end
    endtask

    task automatic test_load_inflight();
        logic [19:0] exp_ctr[4] = '{20'd0, 20'd1, 20'd5, 20'd6};
        logic [99:0] exp_nonce[4] = '{100'h1, 100'h1, 100'h2, 100'h2};
        logic [99:0] got_nonce;
        popped_ctr.delete(); popped_data.delete();
        ks_ready = 1'b1; req_valid = 1'b1;
        tick(); tick();
        ccm_ctr_nonce = 100'h2; ctr_init = 20'd5; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        req_valid = 1'b0;
        wait_idle();
        n_checks++;
        if (popped_ctr.size() != 4) begin n_fail++; $display("[TB] FAIL inflight_count: got %0d expected 4", popped_ctr.size()); end
        for (int i = 0; i < popped_ctr.size() && i < 4; i++) begin
            got_nonce = popped_data[i][119:20];
            n_checks += 2;
            if (popped_ctr[i] !== exp_ctr[i]) begin n_fail++; $display("[TB] FAIL inflight_ctr[%0d]: got %h expected %h", i, popped_ctr[i], exp_ctr[i]); end
            if (got_nonce !== exp_nonce[i]) begin n_fail++; $display("[TB] FAIL inflight_nonce[%0d]: got %h expected %h", i, got_nonce, exp_nonce[i]); end
        end
    endtask

    task automatic test_key_hold();
        logic [127:0] exp_blk = {8'h59, 100'h2, 20'h7};
        popped_data.delete();
        key_aes = '0; ks_ready = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; key_aes = '1;
        wait_idle();
        key_aes = '0;
        n_checks++;
        if (popped_data.size() != 1) begin
            n_fail++; $display("[TB] FAIL key_count: got %0d expected 1", popped_data.size());
        end else if (popped_data[0] !== exp_blk) begin
            n_fail++; $display("[TB] FAIL key_sampled: got %h expected %h", popped_data[0], exp_blk);
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        ks_ready = 1'b0; req_valid = 1'b1;
        tick(); tick();
        req_valid = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (ks_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_pre_valid: got %b expected 1", ks_valid); end
        reset = 1'b0;
        #1;
        n_checks += 4;
        if (ks_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valid: got %b expected 0", ks_valid); end
        if (ks_data !== '0) begin n_fail++; $display("[TB] FAIL midrst_data: got %h expected 0", ks_data); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ready: got %b expected 0", req_ready); end
        tick();
        reset = 1'b1; ks_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ks_valid) seen++;
        end
        n_checks += 2;
        if (seen != 0) begin n_fail++; $display("[TB] FAIL midrst_stale: got %0d output cycles expected 0", seen); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy_after: got %b expected 0", busy); end
        tick();
    endtask

    task automatic test_tdly1();
        logic [127:0] exp1 = {8'h59, 100'h1, 20'h0};
        key_aes = '0; ccm_ctr_nonce = 100'h1; ccm_ctr_flag = 8'h59; ctr_init = 20'h0;
        load1 = 1'b1; tick(); load1 = 1'b0;
        n_checks += 2;
        if (ks_valid1 !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_idle_valid: got %b expected 0", ks_valid1); end
        if (req_ready1 !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_ready: got %b expected 1", req_ready1); end
        req_valid1 = 1'b1; tick(); req_valid1 = 1'b0;
        n_checks += 4;
        if (ks_valid1 !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_latency: got ks_valid=%b expected 1", ks_valid1); end
        if (ks_data1 !== exp1) begin n_fail++; $display("[TB] FAIL t1_data: got %h expected %h", ks_data1, exp1); end
        if (ks_ctr1 !== 20'h0) begin n_fail++; $display("[TB] FAIL t1_ctr: got %h expected 0", ks_ctr1); end
        if (busy1 !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_busy: got %b expected 1", busy1); end
        tick();
        n_checks += 2;
        if (ks_valid1 !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_valid_after_pop: got %b expected 0", ks_valid1); end
        if (busy1 !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_busy_after_pop: got %b expected 0", busy1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_load_inflight();
        test_key_hold();
        test_reset_midflight();
        test_tdly1();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("[TB] FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
